// File: rtl/max_tree_service.sv
// rtl/max_tree_service.sv - pipelined N-term max / max* tree with index and output saturation; optional max* correction under MAX_TREE_SERVICE_MAX_STAR_CORR_EN
module max_tree_service #(
    parameter int                   DWIDTH    = 16,
    parameter int                   NUM_TERMS = 4,
    parameter logic [NUM_TERMS-1:0] OPP_MASK  = '0,
    parameter int                   CORR_THR  = 2,
    parameter int                   CORR_VAL  = 1,
    localparam int                  IDXW      = ($clog2(NUM_TERMS) > 0) ? $clog2(NUM_TERMS) : 1
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              i_valid,
    input  logic [2*NUM_TERMS*DWIDTH-1:0]     i_args,
    output logic                              o_valid,
    output logic [DWIDTH-1:0]                 o_max_result,
    output logic [IDXW-1:0]                   o_max_idx
);

    localparam int LOG2N = $clog2(NUM_TERMS);
    // Two guard bits: a sum/difference of two DWIDTH values never wraps.
    localparam int IW    = DWIDTH + 2;
    // Tree nodes: leaves 0..N-1, then each level packed after the previous one;
    // node N+j has children 2j and 2j+1, the root is node NN-1.
    localparam int NN    = 2 * NUM_TERMS - 1;

    localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {(DWIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {(DWIDTH-1){1'b0}}};

`ifdef MAX_TREE_SERVICE_MAX_STAR_CORR_EN
    localparam logic signed [IW:0]   THR_POS = CORR_THR[IW:0];
    localparam logic signed [IW:0]   THR_NEG = -THR_POS;
    localparam logic signed [IW-1:0] VAL_W   = CORR_VAL[IW-1:0];
`endif

    logic [LOG2N:0]          vld;
    logic signed [IW-1:0]    term_val [0:NUM_TERMS-1];
    logic signed [IW-1:0]    node_val [0:NN-2];
    logic [IDXW-1:0]         node_idx [0:NN-2];
    logic signed [IW-1:0]    win_val  [0:NN-1];
    logic [IDXW-1:0]         win_idx  [0:NN-1];
    logic [DWIDTH-1:0]       root_sat;

    // First node id of a tree level (level 0 = leaves).
    function automatic int lvl_base(input int lvl);
        return 2 * NUM_TERMS - ((2 * NUM_TERMS) >> lvl);
    endfunction

    function automatic logic [IW-1:0] sext(input logic [DWIDTH-1:0] v);
        return {{2{v[DWIDTH-1]}}, v};
    endfunction

    // Valid shift register: one bit per pipeline register, no stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld <= '0;
        end else begin
            vld <= {vld[LOG2N-1:0], i_valid};
        end
    end

    assign o_valid = vld[LOG2N];

    // Per-term a +/- b at full internal width, operation selected by OPP_MASK.
    always_comb begin
        for (int k = 0; k < NUM_TERMS; k++) begin
            if (OPP_MASK[k]) begin
                term_val[k] = sext(i_args[(2*k)*DWIDTH +: DWIDTH]) - sext(i_args[(2*k+1)*DWIDTH +: DWIDTH]);
            end else begin
                term_val[k] = sext(i_args[(2*k)*DWIDTH +: DWIDTH]) + sext(i_args[(2*k+1)*DWIDTH +: DWIDTH]);
            end
        end
    end

    // Pairwise compare of every tree level; strict '>' sends ties to the right (higher index).
    always_comb begin
        int l;
        int n;
        logic signed [IW:0] diff;
        l    = 0;
        n    = 0;
        diff = '0;
        for (int m = 0; m < NN; m++) begin
            win_val[m] = '0;
            win_idx[m] = '0;
        end
        for (int lvl = 1; lvl <= LOG2N; lvl++) begin
            for (int i = 0; i < (NUM_TERMS >> lvl); i++) begin
                l = lvl_base(lvl - 1) + 2 * i;
                n = lvl_base(lvl) + i;
                if (node_val[l] > node_val[l+1]) begin
                    win_val[n] = node_val[l];
                    win_idx[n] = node_idx[l];
                end else begin
                    win_val[n] = node_val[l+1];
                    win_idx[n] = node_idx[l+1];
                end
`ifdef MAX_TREE_SERVICE_MAX_STAR_CORR_EN
                diff = {node_val[l][IW-1], node_val[l]} - {node_val[l+1][IW-1], node_val[l+1]};
                if ((diff < THR_POS) && (diff > THR_NEG)) begin
                    win_val[n] = win_val[n] + VAL_W;
                end
`endif
            end
        end
    end

    // Clamp the root winner into the DWIDTH signed range.
    always_comb begin
        if (win_val[NN-1] > SAT_MAX) begin
            root_sat = SAT_MAX[DWIDTH-1:0];
        end else if (win_val[NN-1] < SAT_MIN) begin
            root_sat = SAT_MIN[DWIDTH-1:0];
        end else begin
            root_sat = win_val[NN-1][DWIDTH-1:0];
        end
    end

    // Pipeline data registers: each level loads only when its incoming valid is set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int m = 0; m < NN - 1; m++) begin
                node_val[m] <= '0;
                node_idx[m] <= '0;
            end
            o_max_result <= '0;
            o_max_idx    <= '0;
        end else begin
            if (i_valid) begin
                for (int k = 0; k < NUM_TERMS; k++) begin
                    node_val[k] <= term_val[k];
                    node_idx[k] <= IDXW'(k);
                end
            end
            for (int lvl = 1; lvl < LOG2N; lvl++) begin
                if (vld[lvl-1]) begin
                    for (int i = 0; i < (NUM_TERMS >> lvl); i++) begin
                        node_val[lvl_base(lvl) + i] <= win_val[lvl_base(lvl) + i];
                        node_idx[lvl_base(lvl) + i] <= win_idx[lvl_base(lvl) + i];
                    end
                end
            end
            if (vld[LOG2N-1]) begin
                o_max_result <= root_sat;
                o_max_idx    <= win_idx[NN-1];
            end
        end
    end

endmodule

// File: tb/tb_max_tree_service.sv
// tb/tb_max_tree_service.sv - scoreboard bench for max_tree_service (DWIDTH=16, NUM_TERMS=4, OPP_MASK=4'b0101)
module tb_max_tree_service;

    localparam int DW   = 16;
    localparam int NT   = 4;
    localparam int LAT  = 3;
    localparam int CTHR = 2;
    localparam int CVAL = 1;
    localparam logic [NT-1:0] MASK = 4'b0101;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b1;
    logic              i_valid = 1'b0;
    logic [2*NT*DW-1:0] i_args = '0;
    logic              o_valid;
    logic [DW-1:0]     o_max_result;
    logic [1:0]        o_max_idx;

    max_tree_service #(
        .DWIDTH    (DW),
        .NUM_TERMS (NT),
        .OPP_MASK  (MASK),
        .CORR_THR  (CTHR),
        .CORR_VAL  (CVAL)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .i_valid      (i_valid),
        .i_args       (i_args),
        .o_valid      (o_valid),
        .o_max_result (o_max_result),
        .o_max_idx    (o_max_idx)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int val;
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_val = 0;
    int   last_idx = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: terms by plain arithmetic, then max (ties -> highest index) or max* tree, then clamp.
    task automatic model(input logic [2*NT*DW-1:0] args, output int val, output int idx);
        int t[NT];
        int a, b;
        int v[$];
        int ix[$];
        int nv[$];
        int nix[$];
        int w, wi, d;
        for (int k = 0; k < NT; k++) begin
            a = $signed(args[(2*k)*DW +: DW]);
            b = $signed(args[(2*k+1)*DW +: DW]);
            t[k] = MASK[k] ? a - b : a + b;
        end
`ifdef MAX_TREE_SERVICE_MAX_STAR_CORR_EN
        for (int k = 0; k < NT; k++) begin
            v.push_back(t[k]);
            ix.push_back(k);
        end
        while (v.size() > 1) begin
            nv.delete();
            nix.delete();
            for (int p = 0; p < v.size(); p += 2) begin
                if (v[p] > v[p+1]) begin
                    w = v[p]; wi = ix[p];
                end else begin
                    w = v[p+1]; wi = ix[p+1];
                end
                d = v[p] - v[p+1];
                if (d < 0) d = -d;
                if (d < CTHR) w = w + CVAL;
                nv.push_back(w);
                nix.push_back(wi);
            end
            v = nv;
            ix = nix;
        end
        val = v[0];
        idx = ix[0];
`else
        val = t[0];
        idx = 0;
        for (int k = 1; k < NT; k++) begin
            if (t[k] >= val) begin
                val = t[k];
                idx = k;
            end
        end
`endif
        if (val > 32767) val = 32767;
        if (val < -32768) val = -32768;
    endtask

    function automatic logic [2*NT*DW-1:0] pk(input int v[2*NT]);
        logic [2*NT*DW-1:0] r;
        int x;
        r = '0;
        for (int j = 0; j < 2*NT; j++) begin
            x = v[j];
            r[j*DW +: DW] = x[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [2*NT*DW-1:0] rnd_args();
        logic [2*NT*DW-1:0] r;
        for (int j = 0; j < 2*NT; j++) begin
            case ($urandom_range(0, 7))
                0:       r[j*DW +: DW] = 16'h7fff;
                1:       r[j*DW +: DW] = 16'h8000;
                default: r[j*DW +: DW] = DW'($urandom);
            endcase
        end
        return r;
    endfunction

    // Called just after a rising edge; the vector is sampled on the next edge.
    task automatic send(input logic [2*NT*DW-1:0] args);
        exp_t e;
        model(args, e.val, e.idx);
        e.cyc = cyc + LAT;
        sb.push_back(e);
        i_valid = 1'b1;
        i_args  = args;
        @(posedge aclk);
        #1;
        i_valid = 1'b0;
        i_args  = rnd_args();
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            i_args = rnd_args();
            @(posedge aclk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every o_valid, checks hold and reset values otherwise.
    always @(negedge aclk) begin
        exp_t e;
        if (!aresetn) begin
            chk("rst_valid", int'(o_valid), 0);
            chk("rst_result", int'($signed(o_max_result)), 0);
            chk("rst_idx", int'(o_max_idx), 0);
        end else if (o_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", int'(o_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("result", int'($signed(o_max_result)), e.val);
                chk("idx", int'(o_max_idx), e.idx);
                last_val = e.val;
                last_idx = e.idx;
            end
        end else begin
            chk("hold_result", int'($signed(o_max_result)), last_val);
            chk("hold_idx", int'(o_max_idx), last_idx);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset hold with valid high and random args.
        #1;
        aresetn = 1'b0;
        i_valid = 1'b1;
        repeat (5) begin
            i_args = rnd_args();
            @(posedge aclk);
            #1;
        end
        i_valid = 1'b0;
        aresetn = 1'b1;
        idle(2);

        // Single vector: terms 7, 6, -10, -2.
        send(pk('{10, 3, 5, 1, 20, 30, -4, 2}));
        idle(5);

        // Saturation high and low with tie.
        send(pk('{0, 0, 32767, 32767, 0, 0, 0, 0}));
        send(pk('{-32768, 32767, -32768, -32768, -32768, 32767, -32768, -32768}));
        idle(5);

        // Streaming with a gap.
        send(pk('{1, 2, 3, 4, 5, 6, 7, 8}));
        send(pk('{-50, 9, -1, -2, 40, -3, 11, 12}));
        send(pk('{100, 1, 0, 0, 99, 0, -5, 5}));
        idle(1);
        send(pk('{-7, 7, -8, 0, 3, 3, -9, 1}));
        idle(5);

        // All four terms equal to 100.
        send(pk('{150, 50, 60, 40, 100, 0, 0, 100}));
        idle(5);

        // Randomised traffic with random gaps.
        for (int r = 0; r < 60; r++) begin
            send(rnd_args());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        // Async reset mid-flight, dropped between clock edges.
        send(pk('{30, 1, 2, 2, 0, 0, 1, 1}));
        send(pk('{5, 5, 5, 5, 5, 5, 5, 5}));
        @(posedge aclk);
        #1;
        #1;
        aresetn = 1'b0;
        sb.delete();
        last_val = 0;
        last_idx = 0;
        #1;
        chk("async_valid", int'(o_valid), 0);
        chk("async_result", int'($signed(o_max_result)), 0);
        chk("async_idx", int'(o_max_idx), 0);
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(5);
        send(pk('{-100, 20, 300, -1, 7, 8, 0, 299}));
        idle(6);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_tree_service.md
Name: max_tree_service

Overview:
- Pipelined N-term max / max* unit for the SISO decoder's forward, backward and LLR recursions.
- Computes max over k of (a_k +/- b_k) for NUM_TERMS terms, reporting the winning term index.
- Generalises the fixed two-term max calculator:
  - parametric term count and per-term add/subtract mask
  - valid handshake
  - output saturation
  - optional Jacobian (max*) correction
- Sits between branch-metric/state-metric registers and the metric normalisation logic.

Parameters:
- DWIDTH, 16, signed width of each argument and of the result.
- NUM_TERMS, 4, number of a+/-b terms; power of two, 2..16.
- OPP_MASK, 0, NUM_TERMS-bit mask; bit k=1 means term k = a_k - b_k, else a_k + b_k.
- CORR_THR, 2, max* correction threshold on |x-y| (used only with the macro).
- CORR_VAL, 1, max* correction value in LSBs (used only with the macro).

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- i_valid  in  1  input vector valid.
- i_args  in  2*NUM_TERMS*DWIDTH  packed signed args; arg j at [(j+1)*DWIDTH-1 : j*DWIDTH]; a_k = arg 2k, b_k = arg 2k+1.
- o_valid  out  1  result valid, one-cycle pulse per input vector.
- o_max_result  out  DWIDTH  saturated signed max.
- o_max_idx  out  max(1,$clog2(NUM_TERMS))  index of winning term.

Behaviour:
- Reset: asynchronous; on aresetn low, all pipeline data, valids and outputs go to 0 immediately.
  - o_valid=0, o_max_result=0, o_max_idx=0.
  - Vectors in flight are discarded. No output appears for them after release.
- Stage 0 (one register):
  - term_k = a_k +/- b_k per OPP_MASK, computed at DWIDTH+2 bits, sign-extended, no wrap.
  - Each term is tagged with index k.
- Compare stages 1..LOG2N (LOG2N = $clog2(NUM_TERMS)), one register each:
  - Binary tree over adjacent pairs (left = lower index).
  - Winner = left if left > right (strict), else right. Ties therefore go to the higher index.
  - Winner's value and index propagate.
- Output stage: the last compare register holds the saturated value:
  - > 2^(DWIDTH-1)-1 clamps to max.
  - < -2^(DWIDTH-1) clamps to min.
- Latency: o_valid asserts exactly LOG2N+1 cycles after the i_valid sample. NUM_TERMS=2 gives 2 cycles.
- Throughput: one vector per cycle, no stall, no backpressure.
- Valid chain: a shift register of LOG2N+1 bits. Data registers load only when their stage's incoming valid is 1, otherwise they hold.
- o_max_result and o_max_idx hold their last value while o_valid=0. Gaps in i_valid are reproduced exactly at o_valid.
- i_args is ignored when i_valid=0.

Optional Feature:
- Macro: MAX_TREE_SERVICE_MAX_STAR_CORR_EN.
- Defined:
  - Each compare stage outputs max(x,y) + (|x-y| < CORR_THR ? CORR_VAL : 0).
  - Correction is computed in the same cycle, so latency is unchanged.
  - Internal width stays DWIDTH+2; saturation still applies at output.
  - The index follows the same tie rule.
- Undefined: pure max; CORR_THR and CORR_VAL are ignored and no correction logic is synthesised.

Test Plan:
All scenarios use DWIDTH=16, NUM_TERMS=4, OPP_MASK=4'b0101 (latency 3) unless noted.
1. Reset hold:
   - aresetn low for 5 cycles with random i_args and i_valid=1 -> o_valid=0, o_max_result=0, o_max_idx=0 throughout.
2. Single vector:
   - args (a,b) = (10,3), (5,1), (20,30), (-4,2); terms 7, 6, -10, -2.
   - -> o_valid pulse exactly 3 cycles later, o_max_result=7, o_max_idx=0.
3. Saturation:
   - t1 = 32767+32767 -> result 32767, idx 1.
   - Second vector: (-32768,32767), (-32768,-32768), (-32768,32767), (-32768,-32768); terms -65535, -65536, -65535, -65536.
   - -> result -32768, idx 2 (tie rule).
4. Streaming:
   - Valid pattern 1,1,1,0,1 with distinct vectors -> o_valid pattern 1,1,1,0,1 delayed 3 cycles.
   - Results in order; outputs hold during the gap.
5. Ties and max*:
   - All terms 100, no macro -> result 100, idx 3.
   - Same stimulus, macro defined with CORR_THR=2, CORR_VAL=1 -> result 102, idx 3.
   - Two levels each add 1.
6. Async reset mid-flight:
   - Two vectors accepted; drop aresetn between clock edges -> o_valid and outputs clear to 0 without a clock edge.
   - After release, no output for the discarded vectors.
   - A new vector then returns correctly after 3 cycles.
